// File: rtl/ctc_greedy_decoder.sv
// CTC greedy decoder: per-frame argmax, repeat-collapse and blank removal, labels out through a FWFT FIFO.
// Optional `CTC_CONF_EN adds label_score (winning frame score stored beside each label).
//
// state  | meaning
// IDLE   | waiting for start
// SCAN   | accepting class-score beats, tracking running argmax
// COMMIT | one-cycle bubble: collapse/blank filter, push label
// DRAIN  | all frames scanned, waiting for the label FIFO to empty
module ctc_greedy_decoder #(
    parameter int DATA_WIDTH  = 24,
    parameter int FRACT_WIDTH = 13,
    parameter int NUM_CLASS   = 5991,
    parameter int CLS_W       = 13,
    parameter int BLANK_IDX   = 0,
    parameter int T_STEPS     = 41,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         score_valid,
    output logic                         score_ready,
    input  logic signed [DATA_WIDTH-1:0] score_data,
    input  logic                         score_last,
    output logic                         label_valid,
    input  logic                         label_ready,
    output logic [CLS_W-1:0]             label_data,
`ifdef CTC_CONF_EN
    output logic [DATA_WIDTH-1:0]        label_score,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         err_len
);

`ifdef CTC_CONF_EN
    localparam int FW = CLS_W + DATA_WIDTH;
`else
    localparam int FW = CLS_W;
`endif
    localparam int FRM_W = $clog2(T_STEPS + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASS - 1);
    localparam logic [CLS_W-1:0] BLANK    = CLS_W'(BLANK_IDX);
    localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(T_STEPS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    if ((1 << CLS_W) < NUM_CLASS) begin : g_bad_cls_w
        $error("CLS_W too narrow for NUM_CLASS");
    end
    if (FIFO_DEPTH < T_STEPS) begin : g_bad_depth
        $error("FIFO_DEPTH must cover T_STEPS labels");
    end
    if (FRACT_WIDTH >= DATA_WIDTH || BLANK_IDX >= NUM_CLASS) begin : g_bad_fmt
        $error("inconsistent score format or blank index");
    end

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DRAIN} state_t;
    state_t state, state_nxt;

    logic [CLS_W-1:0]             cls_cnt, idx, prev_idx;
    logic [FRM_W-1:0]             frm_cnt;
    logic signed [DATA_WIDTH-1:0] max_score;
    logic [FW-1:0]                mem [FIFO_DEPTH];
    logic [FW-1:0]                fifo_in, rd_word;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [CNT_W-1:0]             count;
    logic                         push, pop, empty, beat, last_beat;

    assign beat      = score_valid && score_ready;
    assign last_beat = (cls_cnt == LAST_CLS);
    assign empty     = (count == '0);
    assign pop       = label_valid && label_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        score_ready = 1'b0;
        done        = 1'b0;
        push        = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = SCAN;
            SCAN: begin
                score_ready = 1'b1;
                if (score_valid && last_beat) state_nxt = COMMIT;
            end
            COMMIT: begin
                push      = (idx != BLANK) && (idx != prev_idx);
                state_nxt = (frm_cnt == LAST_FRM) ? DRAIN : SCAN;
            end
            DRAIN: begin
                if (empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_cnt   <= '0;
            frm_cnt   <= '0;
            idx       <= '0;
            prev_idx  <= BLANK;
            max_score <= '0;
            err_len   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cls_cnt  <= '0;
                frm_cnt  <= '0;
                err_len  <= 1'b0;
                prev_idx <= BLANK;
            end
            if (beat) begin
                cls_cnt <= last_beat ? '0 : cls_cnt + CLS_W'(1);
                // strict compare keeps the lowest index on ties
                if (cls_cnt == '0 || score_data > max_score) begin
                    max_score <= score_data;
                    idx       <= cls_cnt;
                end
                if (score_last != last_beat) err_len <= 1'b1;
            end
            if (state == COMMIT) begin
                prev_idx <= idx;
                if (frm_cnt != LAST_FRM) frm_cnt <= frm_cnt + FRM_W'(1);
            end
        end
    end

`ifdef CTC_CONF_EN
    assign fifo_in     = {max_score, idx};
    assign label_score = empty ? '0 : rd_word[FW-1:CLS_W];
`else
    assign fifo_in = idx;
`endif
    assign rd_word     = mem[rd_ptr];
    assign label_valid = !empty;
    assign label_data  = empty ? '0 : rd_word[CLS_W-1:0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ctc_greedy_decoder.sv
// Directed bench for ctc_greedy_decoder at reduced size (8 classes, 6 frames);
// a label scoreboard is filled from a bench-side argmax/collapse model.
module tb_ctc_greedy_decoder;
    localparam int DW = 24, NC = 8, CW = 4, BL = 0, TS = 6, FD = 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic score_valid = 1'b0, score_last = 1'b0, label_ready = 1'b1;
    logic signed [DW-1:0] score_data = '0;
    logic score_ready, label_valid, busy, done, err_len;
    logic [CW-1:0] label_data;
`ifdef CTC_CONF_EN
    logic [DW-1:0] label_score;
`endif

    int checks = 0, passed = 0;
    int lbl_seen = 0, busy_cyc = 0, m_prev = BL;
    logic [31:0] exp_q[$];
    logic signed [DW-1:0] fs [NC];

    ctc_greedy_decoder #(
        .DATA_WIDTH(DW), .FRACT_WIDTH(13), .NUM_CLASS(NC), .CLS_W(CW),
        .BLANK_IDX(BL), .T_STEPS(TS), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .score_valid(score_valid), .score_ready(score_ready),
        .score_data(score_data), .score_last(score_last),
        .label_valid(label_valid), .label_ready(label_ready), .label_data(label_data),
`ifdef CTC_CONF_EN
        .label_score(label_score),
`endif
        .busy(busy), .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        busy_cyc += int'(busy);
        if (rst_n && label_valid && label_ready) begin
            logic [31:0] e;
            lbl_seen++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            chk("label", 32'(label_data), e);
        end
    end

    task automatic make_frame(input int win, input int tie, input bit neg);
        for (int c = 0; c < NC; c++) begin
            int v;
            v = neg ? -2000 - int'($urandom_range(0, 1000)) : int'($urandom_range(0, 800));
            fs[c] = DW'(v);
        end
        fs[win] = neg ? DW'(-5) : DW'(900);
        if (tie >= 0) fs[tie] = fs[win];
    endtask

    task automatic beat(input logic signed [DW-1:0] d, input logic l);
        int t = 0;
        score_valid = 1'b1; score_data = d; score_last = l;
        do begin @(negedge clk); t++; end while (!score_ready && t < 100);
        if (!score_ready) chk("beat_timeout", 32'(score_ready), 1);
        @(posedge clk); #1;
        score_valid = 1'b0; score_last = 1'b0;
    endtask

    task automatic send_frame(input int bad_beat, input int nbeats);
        int best = 0;
        for (int c = 1; c < NC; c++) if (fs[c] > fs[best]) best = c;
        if (best != BL && best != m_prev) exp_q.push_back(32'(best));
        m_prev = best;
        for (int c = 0; c < nbeats; c++) beat(fs[c], (c == NC - 1) || (c == bad_beat));
    endtask

    task automatic run_frame(input int win, input int tie, input bit neg);
        make_frame(win, tie, neg);
        send_frame(-1, NC);
    endtask

    task automatic do_start();
        m_prev = BL; busy_cyc = 0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 500);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_at_done"}, 32'(busy), 1);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
        @(negedge clk);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_pulse"}, 32'(done), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_score_ready", 32'(score_ready), 0);
        chk("rst_label_valid", 32'(label_valid), 0);
        chk("rst_label_data", 32'(label_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_len", 32'(err_len), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // argmax sequence 3,3,0,3,5,5 -> labels 3,3,5
        do_start();
        chk("busy_after_start", 32'(busy), 1);
        run_frame(3, -1, 0); run_frame(3, -1, 0); run_frame(0, -1, 0);
        run_frame(3, -1, 0); run_frame(5, -1, 0); run_frame(5, -1, 0);
        chk("seq1_labels_queued", 32'(exp_q.size()), 0);
        wait_done("seq1");
        chk("seq1_busy_cycles", 32'(busy_cyc), 32'(TS * (NC + 1) + 1));
        chk("seq1_label_count", 32'(lbl_seen), 3);
        chk("seq1_err_len", 32'(err_len), 0);

        // all blank: no labels at all
        base = lbl_seen;
        do_start();
        for (int f = 0; f < TS; f++) run_frame(0, -1, f[0]);
        wait_done("blank");
        chk("blank_no_labels", 32'(lbl_seen - base), 0);

        // ties and negative-only scores
        do_start();
        run_frame(2, 6, 0); run_frame(4, -1, 1); run_frame(0, -1, 0);
        run_frame(2, 6, 1); run_frame(7, -1, 0); run_frame(1, 5, 1);
        wait_done("ties");

        // label_ready held low for the whole sequence
        label_ready = 1'b0;
        base = lbl_seen;
        do_start();
        run_frame(1, -1, 0); run_frame(2, -1, 0); run_frame(3, -1, 1);
        run_frame(4, -1, 0); run_frame(5, -1, 1); run_frame(1, -1, 0);
        repeat (20) @(negedge clk);
        chk("hold_no_done", 32'(done), 0);
        chk("hold_busy", 32'(busy), 1);
        chk("hold_valid", 32'(label_valid), 1);
        chk("hold_head", 32'(label_data), exp_q[0]);
        @(posedge clk); #1;
        label_ready = 1'b1;
        wait_done("hold");
        chk("hold_label_count", 32'(lbl_seen - base), 6);

        // misaligned score_last on beat 4 of frame 1
        do_start();
        run_frame(2, -1, 0);
        chk("errlen_before", 32'(err_len), 0);
        make_frame(6, -1, 0); send_frame(4, NC);
        chk("errlen_set", 32'(err_len), 1);
        run_frame(6, -1, 0); run_frame(0, -1, 0); run_frame(6, -1, 1); run_frame(3, -1, 0);
        wait_done("errlen");
        chk("errlen_sticky", 32'(err_len), 1);

        // new start clears err_len; async reset in frame 3
        do_start();
        chk("errlen_cleared", 32'(err_len), 0);
        run_frame(4, -1, 0); run_frame(1, -1, 0); run_frame(7, -1, 0);
        make_frame(2, -1, 0); send_frame(-1, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_score_ready", 32'(score_ready), 0);
        chk("midrst_label_valid", 32'(label_valid), 0);
        chk("midrst_label_data", 32'(label_data), 0);
        chk("midrst_done", 32'(done), 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // fresh sequence after reset: 5,0,5,1,1,2 -> labels 5,5,1,2
        base = lbl_seen;
        do_start();
        run_frame(5, -1, 0); run_frame(0, -1, 1); run_frame(5, -1, 0);
        run_frame(1, -1, 1); run_frame(1, -1, 0); run_frame(2, 3, 0);
        wait_done("fresh");
        chk("fresh_label_count", 32'(lbl_seen - base), 4);
        chk("fresh_err_len", 32'(err_len), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
